// File: rtl/onehot_encoder_seq.sv
// onehot_encoder_seq: takes a multi-hot vector and hands out the binary index
// of every set line, lowest index first, one index per output handshake.
// A vector is held until its last index is taken. Only then is a new one accepted.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. The producer must hold in_vec and
// in_valid stable until in_ready is seen. out_bin and out_last stay stable
// while out_valid && !out_ready. Every output comes from a flop, so there is
// no combinational path from any input to any output.
module onehot_encoder_seq #(
  parameter int BINBUSWIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2**BINBUSWIDTH-1:0]   in_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BINBUSWIDTH-1:0]      out_bin,
  output logic                        out_last,
  output logic                        empty_pulse
);

  localparam int VECW = 2**BINBUSWIDTH;
  localparam logic [VECW-1:0] ONE = VECW'(1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [VECW-1:0]   pend;
  logic [VECW-1:0]   pend_nxt;
  logic              empty_nxt;

  // Priority encoder: the scan runs from the top bit down, so the lowest set bit is the last to write idx and wins.
  function automatic logic [BINBUSWIDTH-1:0] lowest_index(input logic [VECW-1:0] v);
    logic [BINBUSWIDTH-1:0] idx;
    idx = '0;
    for (int i = VECW - 1; i >= 0; i--) begin
      if (v[i]) idx = BINBUSWIDTH'(i);
    end
    return idx;
  endfunction

  // The vector has exactly one bit set.
  function automatic logic single_bit(input logic [VECW-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  // Next state and next pending set. The outputs are then registered from these values.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    empty_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pend_nxt  = in_vec;
            state_nxt = EMIT;
          end else begin
            empty_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          // Clear the lowest set bit, which is the index being taken now.
          pend_nxt = pend & (pend - ONE);
          if (out_last) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        pend_nxt  = '0;
      end
    endcase
  end

  // State, pending set and all outputs update together, so the outputs always describe the current pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_bin     <= '0;
      out_last    <= 1'b0;
      empty_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend        <= pend_nxt;
      empty_pulse <= empty_nxt;
      in_ready    <= (state_nxt == IDLE);
      out_valid   <= (state_nxt == EMIT);
      out_bin     <= (state_nxt == EMIT) ? lowest_index(pend_nxt) : '0;
      out_last    <= (state_nxt == EMIT) ? single_bit(pend_nxt) : 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Bench for onehot_encoder_seq. The reference model works on a queue of the
// indices still to be emitted. The DUT is compared against it on every falling
// edge. The directed tests also pin literal values.
module tb_onehot_encoder_seq;

  localparam int BW = 5;
  localparam int VW = 2**BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_bin;
  logic          out_last;
  logic          empty_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the indices still to be emitted for the vector being held, plus the empty flag.
  logic [BW-1:0] exp_q[$];
  logic          m_empty = 1'b0;
  // Indices actually handed over by the DUT.
  logic [BW-1:0] log_q[$];

  onehot_encoder_seq #(.BINBUSWIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_last(out_last), .empty_pulse(empty_pulse)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update. While idle (queue empty) it accepts a vector. Otherwise it pops on out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_empty = 1'b0;
    end else if (exp_q.size() == 0) begin
      m_empty = 1'b0;
      if (in_valid) begin
        if (in_vec == '0) m_empty = 1'b1;
        else for (int i = 0; i < VW; i++) if (in_vec[i]) exp_q.push_back(BW'(i));
      end
    end else begin
      m_empty = 1'b0;
      if (out_ready) void'(exp_q.pop_front());
    end
  end

  // Compare process: the inputs are driven at posedge+1, so they are stable here.
  always @(negedge clk) begin
    check("in_ready",    32'(in_ready),    32'(exp_q.size() == 0));
    check("out_valid",   32'(out_valid),   32'(exp_q.size() != 0));
    check("out_bin",     32'(out_bin),     (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    check("out_last",    32'(out_last),    32'(exp_q.size() == 1));
    check("empty_pulse", 32'(empty_pulse), 32'(m_empty));
    if (rst_n && out_valid && out_ready) log_q.push_back(out_bin);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a vector for one cycle. Call it only while the block is idle.
  task automatic offer(input logic [VW-1:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (out_valid && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [VW-1:0] acc;
    bit            in_order;

    #1 rst_n = 1'b0;
    repeat (2) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bin", 32'(out_bin), 32'd0);
    check("rst_empty", 32'(empty_pulse), 32'd0);
    rst_n = 1'b1;
    step();

    // Single bit: the decoder inverse case.
    out_ready = 1'b0;
    offer(32'h0000_0010);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_bin", 32'(out_bin), 32'd4);
    check("t1_last", 32'(out_last), 32'd1);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("t1_back_idle", 32'(in_ready), 32'd1);
    check("t1_valid_off", 32'(out_valid), 32'd0);

    // Back-to-back indices with the top bit, while out_ready is held high (also while idle).
    step();
    offer(32'h8000_0005);
    check("t2_bin0", 32'(out_bin), 32'd0);
    check("t2_last0", 32'(out_last), 32'd0);
    check("t2_rdy0", 32'(in_ready), 32'd0);
    step();
    check("t2_bin2", 32'(out_bin), 32'd2);
    check("t2_last2", 32'(out_last), 32'd0);
    check("t2_rdy2", 32'(in_ready), 32'd0);
    step();
    check("t2_bin31", 32'(out_bin), 32'd31);
    check("t2_last31", 32'(out_last), 32'd1);
    step();
    check("t2_idle", 32'(in_ready), 32'd1);

    // Backpressure: out_ready goes 0,1,0,0,1.
    out_ready = 1'b0;
    step();
    log_q.delete();
    offer(32'h0000_0003);
    check("t3_hold0a", 32'(out_bin), 32'd0);
    out_ready = 1'b0; step();
    check("t3_hold0b", 32'(out_bin), 32'd0);
    out_ready = 1'b1; step();
    check("t3_bin1", 32'(out_bin), 32'd1);
    check("t3_last1", 32'(out_last), 32'd1);
    out_ready = 1'b0; step();
    check("t3_hold1a", 32'(out_bin), 32'd1);
    out_ready = 1'b0; step();
    check("t3_hold1b", 32'(out_bin), 32'd1);
    out_ready = 1'b1; step();
    check("t3_done", 32'(out_valid), 32'd0);
    check("t3_handshakes", 32'(log_q.size()), 32'd2);

    // An all-zero vector is discarded with a one-cycle pulse.
    out_ready = 1'b0;
    offer('0);
    check("t4_pulse", 32'(empty_pulse), 32'd1);
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_ready", 32'(in_ready), 32'd1);
    step();
    check("t4_pulse_off", 32'(empty_pulse), 32'd0);

    // All ones with random out_ready. Each index is decoded back and ORed in.
    log_q.delete();
    offer('1);
    for (int n = 0; n < 400 && out_valid; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    out_ready = 1'b0;
    check("t5_timeout", 32'(out_valid), 32'd0);
    check("t5_count", 32'(log_q.size()), 32'd32);
    acc = '0;
    in_order = 1'b1;
    foreach (log_q[i]) begin
      acc = acc | (VW'(1) << log_q[i]);
      if (32'(log_q[i]) != 32'(i)) in_order = 1'b0;
    end
    check("t5_decoded_or", acc, 32'hFFFF_FFFF);
    check("t5_order", 32'(in_order), 32'd1);

    // Reset while the third index of 0xFF is being presented.
    step();
    out_ready = 1'b1;
    offer(32'h0000_00FF);
    step();
    check("t6_bin1", 32'(out_bin), 32'd1);
    step();
    check("t6_bin2", 32'(out_bin), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_ready", 32'(in_ready), 32'd1);
    check("t6_async_bin", 32'(out_bin), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("t6_after_ready", 32'(in_ready), 32'd1);
    check("t6_after_valid", 32'(out_valid), 32'd0);
    log_q.delete();
    offer(32'h0000_0100);
    check("t6_bin8", 32'(out_bin), 32'd8);
    check("t6_last8", 32'(out_last), 32'd1);
    drain(10);
    check("t6_one_index", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) check("t6_logged8", 32'(log_q[0]), 32'd8);
    out_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
